// File: rtl/instr_queue_pkg.sv
// Shared constants for the fetch -> decode instruction path.
package instr_queue_pkg;

    // Boot PC, presented by the queue whenever it holds nothing.
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    // Canonical no-op word, presented alongside RESET_PC when empty.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instr_queue_ptr_counter.sv
// Wrap-around pointer with synchronous clear and single-step increment.
// Width W wraps naturally modulo 2**W, which matches a power-of-two depth.
module instr_queue_ptr_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_reg;

    // Pointer register: reset and clear both return to slot 0; clear wins over inc.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr_reg <= '0;
        end else if (inc) begin
            ptr_reg <= ptr_reg + 1'b1;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/instr_queue.sv
// In-order (PC, instruction) buffer between fetch and decode.
// Two valid/ready handshakes, single-cycle flush on redirect, no empty bypass:
// a pushed pair reaches the outputs one cycle after its push edge.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = instr_queue_pkg::RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_instr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   entry_pc_reg    [DEPTH];
    logic [31:0]   entry_instr_reg [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;

    // Handshake status depends only on the registered occupancy.
    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);

    // A flush cycle swallows any concurrent push or pop.
    assign push = in_valid  && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    instr_queue_ptr_counter #(.W(AW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    instr_queue_ptr_counter #(.W(AW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    // Per-entry storage; contents are never cleared, validity lives in count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the offered pair into the slot the write pointer names.
            always_ff @(posedge clk) begin
                if (push && (wr_ptr == AW'(gi))) begin
                    entry_pc_reg[gi]    <= in_pc;
                    entry_instr_reg[gi] <= in_instr;
                end
            end
        end
    endgenerate

    // Occupancy update: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Occupancy register: reset, then flush, then normal traffic.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

    // Head read is combinational from state; an empty queue shows boot PC and a nop.
    assign out_pc    = out_valid ? entry_pc_reg[rd_ptr]    : RESET_PC;
    assign out_instr = out_valid ? entry_instr_reg[rd_ptr] : NOP_INSTR;

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: a table of single-cycle vectors with
// hand-computed post-edge expectations, then streaming and reset sequences.
module tb_instr_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int n_compared;
    int n_mismatched;

    instr_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ordy;
        int          e_cnt;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic fl, logic iv, logic [31:0] pc,
                                logic [31:0] ins, logic ordy, int e_cnt,
                                logic e_ir, logic e_ov, logic [31:0] e_pc,
                                logic [31:0] e_ins);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy;
        v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_ins = e_ins;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and land 1 time unit after the edge.
    task automatic apply(input logic rst, input logic fl, input logic iv,
                         input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
        reset = rst; flush = fl; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;

        //                 rst fl iv pc            instr          ordy cnt ir ov  e_pc          e_instr
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,         0,   0,  1, 0, 32'h0000_3000, 32'h0));          // 0 reset
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         0,   0,  1, 0, 32'h0000_3000, 32'h0));          // 1 idle
        vecs.push_back(mk(0, 0, 1, 32'h3000,     32'h3408_0001, 0,   1,  1, 1, 32'h0000_3000, 32'h3408_0001));  // 2 push
        vecs.push_back(mk(0, 0, 1, 32'h3004,     32'h3409_0002, 0,   2,  1, 1, 32'h0000_3000, 32'h3408_0001));  // 3 push
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1,   1,  1, 1, 32'h0000_3004, 32'h3409_0002));  // 4 pop
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1,   0,  1, 0, 32'h0000_3000, 32'h0));          // 5 pop to empty
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1,   0,  1, 0, 32'h0000_3000, 32'h0));          // 6 pop on empty ignored
        vecs.push_back(mk(0, 0, 1, 32'h3000,     32'h1111_0000, 0,   1,  1, 1, 32'h0000_3000, 32'h1111_0000));  // 7 fill
        vecs.push_back(mk(0, 0, 1, 32'h3004,     32'h1111_0001, 0,   2,  1, 1, 32'h0000_3000, 32'h1111_0000));  // 8
        vecs.push_back(mk(0, 0, 1, 32'h3008,     32'h1111_0002, 0,   3,  1, 1, 32'h0000_3000, 32'h1111_0000));  // 9
        vecs.push_back(mk(0, 0, 1, 32'h300C,     32'h1111_0003, 0,   4,  0, 1, 32'h0000_3000, 32'h1111_0000));  // 10 full
        vecs.push_back(mk(0, 0, 1, 32'h3010,     32'h2222_0000, 0,   4,  0, 1, 32'h0000_3000, 32'h1111_0000));  // 11 push while full ignored
        vecs.push_back(mk(0, 0, 1, 32'h3010,     32'h2222_0000, 1,   3,  1, 1, 32'h0000_3004, 32'h1111_0001));  // 12 push+pop while full: pop only
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1,   2,  1, 1, 32'h0000_3008, 32'h1111_0002));  // 13
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1,   1,  1, 1, 32'h0000_300C, 32'h1111_0003));  // 14
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1,   0,  1, 0, 32'h0000_3000, 32'h0));          // 15 drained
        vecs.push_back(mk(0, 0, 1, 32'h4000,     32'h3333_0000, 0,   1,  1, 1, 32'h0000_4000, 32'h3333_0000));  // 16
        vecs.push_back(mk(0, 0, 1, 32'h4004,     32'h3333_0001, 0,   2,  1, 1, 32'h0000_4000, 32'h3333_0000));  // 17
        vecs.push_back(mk(0, 0, 1, 32'h4008,     32'h3333_0002, 0,   3,  1, 1, 32'h0000_4000, 32'h3333_0000));  // 18
        vecs.push_back(mk(0, 1, 1, 32'h400C,     32'h3333_0003, 1,   0,  1, 0, 32'h0000_3000, 32'h0));          // 19 flush beats push/pop
        vecs.push_back(mk(0, 0, 1, 32'h5000,     32'h4444_0000, 0,   1,  1, 1, 32'h0000_5000, 32'h4444_0000));  // 20 after flush

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].ordy);
            $display("vec %0d: rst=%0b fl=%0b iv=%0b pc=%08h ordy=%0b -> count=%0d in_ready=%0b out_valid=%0b out_pc=%08h out_instr=%08h",
                     i, vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy,
                     count, in_ready, out_valid, out_pc, out_instr);
            check($sformatf("vec%0d.count", i),     32'(count),     32'(vecs[i].e_cnt));
            check($sformatf("vec%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d.out_pc", i),    out_pc,         vecs[i].e_pc);
            check($sformatf("vec%0d.out_instr", i), out_instr,      vecs[i].e_ins);
        end

        // Streaming: bring occupancy to 2, then push and pop every cycle for 10 cycles.
        apply(0, 0, 1, 32'h5004, 32'h4444_0001, 0);
        check("stream.prefill_count", 32'(count), 32'd2);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("stream%0d.head_pc", k), out_pc, 32'h5000 + 32'(4 * k));
            apply(0, 0, 1, 32'h5008 + 32'(4 * k), 32'h4444_0002 + 32'(k), 1);
            $display("stream %0d: pushed %08h -> count=%0d out_pc=%08h", k, 32'h5008 + 32'(4 * k), count, out_pc);
            check($sformatf("stream%0d.count", k), 32'(count), 32'd2);
        end
        check("stream.final_head", out_pc, 32'h0000_5028);
        check("stream.final_instr", out_instr, 32'h4444_000A);

        // Reset mid-operation with the queue full and a pop and push offered.
        apply(0, 0, 1, 32'h6000, 32'h5555_0000, 0);
        apply(0, 0, 1, 32'h6004, 32'h5555_0001, 0);
        $display("refill: count=%0d in_ready=%0b", count, in_ready);
        check("refill.count", 32'(count), 32'd4);
        check("refill.in_ready", 32'(in_ready), 32'd0);
        apply(1, 0, 1, 32'h7000, 32'h6666_0000, 1);
        $display("mid reset: count=%0d out_valid=%0b out_pc=%08h", count, out_valid, out_pc);
        check("midreset.count", 32'(count), 32'd0);
        check("midreset.out_valid", 32'(out_valid), 32'd0);
        check("midreset.out_pc", out_pc, 32'h0000_3000);
        check("midreset.out_instr", out_instr, 32'h0);
        apply(0, 0, 1, 32'h3000, 32'h3408_0001, 0);
        $display("post reset push: count=%0d out_pc=%08h out_instr=%08h", count, out_pc, out_instr);
        check("postreset.count", 32'(count), 32'd1);
        check("postreset.out_pc", out_pc, 32'h0000_3000);
        check("postreset.out_instr", out_instr, 32'h3408_0001);

        in_valid = 1'b0; out_ready = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
